// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, 8N1 frame constants and bit-timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uartState_t;

  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;
  localparam int MIN_CLKS_PER_BIT = 8;

  function automatic int clksPerBit(input int clockFrequency, input int baudRate);
    return clockFrequency / baudRate;
  endfunction

  function automatic int halfBit(input int clks);
    return clks / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin (resets to idle-high) with falling-edge detect.
module uart_rx_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic RxWire,
  output logic RxSync,
  output logic RxFall
);

  logic rxMeta_p0;
  logic rxSync_p1;
  logic rxDly_p2;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rxMeta_p0 <= 1'b1;
      rxSync_p1 <= 1'b1;
      rxDly_p2  <= 1'b1;
    end else begin
      rxMeta_p0 <= RxWire;
      rxSync_p1 <= rxMeta_p0;
      rxDly_p2  <= rxSync_p1;
    end
  end

  assign RxSync = rxSync_p1;
  assign RxFall = rxDly_p2 & ~rxSync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit 2-of-3 majority sampling, valid/ready holding register,
// frame-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 1_000_000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RxWire,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  output logic       RxFrameError,
  output logic       RxOverrun,
  output logic       RxBusy
);

  localparam int CLKS_PER_BIT = clksPerBit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_BIT     = halfBit(CLKS_PER_BIT);
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] SAMPLE_A   = TIMER_W'(HALF_BIT - 1);
  localparam logic [TIMER_W-1:0] SAMPLE_B   = TIMER_W'(HALF_BIT);
  localparam logic [TIMER_W-1:0] DECIDE_AT  = TIMER_W'(HALF_BIT + 1);
  localparam logic [2:0]         LAST_BIT   = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : gBaudCheck
    $error("uart_rx: CLOCK_FREQUENCY/BAUD_RATE must give at least 8 clocks per bit");
  end
  if (DATA_BITS != 8 || STOP_BITS != 1) begin : gFrameCheck
    $error("uart_rx: only the 8N1 frame format is implemented");
  end

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uartState_t             state;
  uartState_t             nextState;
  logic [TIMER_W-1:0]     bitTimer;
  logic [2:0]             bitIdx;
  logic                   sampleA;
  logic                   sampleB;
  logic [DATA_BITS-1:0]   shiftReg;
  logic                   rxSync;
  logic                   rxFall;
  logic                   wrap;
  logic                   decide;
  logic                   bitVal;
  logic                   accept;
  logic                   deliverStb;
  logic                   frameErrStb;

  uart_rx_sync uSync (
    .Clk    (Clk),
    .Reset  (Reset),
    .RxWire (RxWire),
    .RxSync (rxSync),
    .RxFall (rxFall)
  );

  assign wrap   = (bitTimer == TIMER_LAST);
  assign decide = (bitTimer == DECIDE_AT);
  assign bitVal = majority3(sampleA, sampleB, rxSync);
  assign accept = RxValid & RxReady;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (rxFall) nextState = START;
      START: begin
        if (decide && bitVal) nextState = IDLE;
        else if (wrap)        nextState = DATA;
      end
      DATA:      if (wrap && bitIdx == LAST_BIT) nextState = STOP;
      STOP:      if (decide) nextState = bitVal ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxSync) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    RxBusy      = (state != IDLE);
    deliverStb  = (state == STOP) && decide && bitVal;
    frameErrStb = (state == STOP) && decide && !bitVal;
  end

  // Timer idles at zero outside the bit-timed states, so entering START starts a fresh bit.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bitTimer <= '0;
      bitIdx   <= '0;
    end else begin
      if (state == IDLE || state == WAIT_HIGH || wrap) bitTimer <= '0;
      else                                             bitTimer <= bitTimer + 1'b1;
      if (state == START)             bitIdx <= '0;
      else if (state == DATA && wrap) bitIdx <= bitIdx + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (bitTimer == SAMPLE_A) sampleA <= rxSync;
    if (bitTimer == SAMPLE_B) sampleB <= rxSync;
    if (state == DATA && decide) shiftReg <= {bitVal, shiftReg[DATA_BITS-1:1]};
  end

  // A delivery that finds the register full and unaccepted is dropped and flagged.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RxData       <= '0;
      RxValid      <= 1'b0;
      RxOverrun    <= 1'b0;
      RxFrameError <= 1'b0;
    end else begin
      RxFrameError <= frameErrStb;
      if (accept) begin
        RxValid   <= 1'b0;
        RxOverrun <= 1'b0;
      end
      if (deliverStb) begin
        if (!RxValid || accept) begin
          RxData  <= shiftReg;
          RxValid <= 1'b1;
        end else begin
          RxOverrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a randomized loopback scored against a byte queue.
module tb_uart_rx;

  localparam int CLOCK_FREQUENCY = 1_000_000;
  localparam int BAUD_RATE       = 9600;
  localparam int CPB             = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HB              = CPB / 2;
  localparam int EXP_LAT         = 3 + 9 * CPB + HB + 1;

  logic       Clk     = 1'b0;
  logic       Reset   = 1'b0;
  logic       RxWire  = 1'b1;
  logic       RxReady = 1'b0;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxFrameError;
  logic       RxOverrun;
  logic       RxBusy;

  int nCompared   = 0;
  int nMismatched = 0;
  int edgeCnt     = 0;
  int lastEdge0   = 0;
  int riseCnt     = 0;
  int riseEdge    = 0;
  int ferrCnt     = 0;
  int ferrEdge    = 0;
  int busyCnt     = 0;
  int ovrCnt      = 0;
  int acceptCnt   = 0;
  bit scoreOn     = 1'b0;
  logic prevValid = 1'b0;
  logic [7:0] expQ[$];
  logic [7:0] loopBytes[4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};
  logic [7:0] txByte;
  int gap;
  int noiseOff;

  uart_rx #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .BAUD_RATE      (BAUD_RATE)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .RxWire      (RxWire),
    .RxData      (RxData),
    .RxValid     (RxValid),
    .RxReady     (RxReady),
    .RxFrameError(RxFrameError),
    .RxOverrun   (RxOverrun),
    .RxBusy      (RxBusy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) edgeCnt++;

  task automatic checkVal(input string tag, input int got, input int exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe registered outputs on the falling edge, clear of the main thread's drive point.
  always @(negedge Clk) begin
    if (RxValid && !prevValid) begin
      riseCnt++;
      riseEdge = edgeCnt;
    end
    if (RxFrameError) begin
      ferrCnt++;
      ferrEdge = edgeCnt;
    end
    if (RxBusy)    busyCnt++;
    if (RxOverrun) ovrCnt++;
    if (scoreOn && RxValid && RxReady) begin
      acceptCnt++;
      checkVal("sbPending", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) checkVal("loopData", int'(RxData), int'(expQ.pop_front()));
    end
    prevValid = RxValid;
  end

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic driveBit(input logic v, input int noiseAt);
    RxWire = v;
    if (noiseAt < 0) begin
      clocks(CPB);
    end else begin
      clocks(noiseAt);
      RxWire = ~v;
      clocks(1);
      RxWire = v;
      clocks(CPB - noiseAt - 1);
    end
  endtask

  // Leaves the line at stopVal; callers restore idle after a forced-low stop bit.
  task automatic sendFrame(input logic [7:0] b, input logic stopVal, input int stopLen, input int noiseAt);
    lastEdge0 = edgeCnt + 1;
    RxWire = 1'b0;
    clocks(CPB);
    for (int i = 0; i < 8; i++) driveBit(b[i], noiseAt);
    RxWire = stopVal;
    clocks(stopLen);
  endtask

  task automatic clearCounts();
    riseCnt = 0; ferrCnt = 0; busyCnt = 0; ovrCnt = 0; acceptCnt = 0;
  endtask

  task automatic pulseReady();
    RxReady = 1'b1;
    clocks(1);
    RxReady = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    clocks(3);
    checkVal("rstData",  int'(RxData), 0);
    checkVal("rstValid", int'(RxValid), 0);
    checkVal("rstFerr",  int'(RxFrameError), 0);
    checkVal("rstOvr",   int'(RxOverrun), 0);
    checkVal("rstBusy",  int'(RxBusy), 0);
    Reset = 1'b1;
    clocks(5);

    clearCounts();
    sendFrame(8'hA5, 1'b1, CPB, -1);
    checkVal("a5Data",    int'(RxData), 'hA5);
    checkVal("a5Valid",   int'(RxValid), 1);
    checkVal("a5Latency", riseEdge - lastEdge0, EXP_LAT);
    checkVal("a5Rises",   riseCnt, 1);
    checkVal("a5Ferr",    ferrCnt, 0);
    pulseReady();
    checkVal("a5Accept",  int'(RxValid), 0);

    clearCounts();
    RxWire = 1'b0;
    clocks(30);
    RxWire = 1'b1;
    clocks(2 * CPB);
    checkVal("glitchBusySeen", int'(busyCnt > 0), 1);
    checkVal("glitchBusyEnd",  int'(RxBusy), 0);
    checkVal("glitchValid",    riseCnt, 0);
    checkVal("glitchFerr",     ferrCnt, 0);
    checkVal("glitchOvr",      ovrCnt, 0);

    clearCounts();
    sendFrame(8'h3C, 1'b1, CPB, HB);
    checkVal("noiseData",  int'(RxData), 'h3C);
    checkVal("noiseValid", int'(RxValid), 1);
    checkVal("noiseFerr",  ferrCnt, 0);
    pulseReady();

    clearCounts();
    sendFrame(8'h3C, 1'b0, 2 * CPB, -1);
    checkVal("ferrBusyLow", int'(RxBusy), 1);
    checkVal("ferrPulses",  ferrCnt, 1);
    checkVal("ferrEdge",    ferrEdge - lastEdge0, EXP_LAT);
    checkVal("ferrNoValid", riseCnt, 0);
    checkVal("ferrValid",   int'(RxValid), 0);
    RxWire = 1'b1;
    clocks(4);
    checkVal("ferrBusyEnd", int'(RxBusy), 0);

    clearCounts();
    sendFrame(8'h11, 1'b1, CPB, -1);
    sendFrame(8'h22, 1'b1, CPB, -1);
    checkVal("ovrData",    int'(RxData), 'h11);
    checkVal("ovrValid",   int'(RxValid), 1);
    checkVal("ovrFlag",    int'(RxOverrun), 1);
    checkVal("ovrRises",   riseCnt, 1);
    pulseReady();
    checkVal("ovrAccValid", int'(RxValid), 0);
    checkVal("ovrAccFlag",  int'(RxOverrun), 0);

    txByte = 8'h5A;
    RxWire = 1'b0;
    clocks(CPB);
    for (int i = 0; i < 4; i++) driveBit(txByte[i], -1);
    RxWire = txByte[4];
    clocks(HB);
    Reset = 1'b0;
    clocks(1);
    checkVal("midRstData",  int'(RxData), 0);
    checkVal("midRstValid", int'(RxValid), 0);
    checkVal("midRstFerr",  int'(RxFrameError), 0);
    checkVal("midRstOvr",   int'(RxOverrun), 0);
    checkVal("midRstBusy",  int'(RxBusy), 0);
    RxWire = 1'b1;
    clocks(3);
    Reset = 1'b1;
    clocks(CPB);
    clearCounts();
    sendFrame(8'h7E, 1'b1, CPB, -1);
    checkVal("postRstData",  int'(RxData), 'h7E);
    checkVal("postRstValid", int'(RxValid), 1);
    checkVal("postRstFerr",  ferrCnt, 0);
    pulseReady();

    clearCounts();
    RxReady = 1'b1;
    scoreOn = 1'b1;
    foreach (loopBytes[k]) begin
      expQ.push_back(loopBytes[k]);
      sendFrame(loopBytes[k], 1'b1, CPB, -1);
    end
    for (int k = 0; k < 6; k++) begin
      txByte   = 8'($urandom_range(0, 255));
      gap      = int'($urandom_range(0, 20));
      noiseOff = ($urandom_range(0, 1) == 1) ? HB + int'($urandom_range(0, 2)) : -1;
      expQ.push_back(txByte);
      sendFrame(txByte, 1'b1, CPB, noiseOff);
      clocks(gap);
    end
    clocks(CPB);
    checkVal("sbDrained",  expQ.size(), 0);
    checkVal("sbAccepted", acceptCnt, 10);
    checkVal("loopFerr",   ferrCnt, 0);
    checkVal("loopOvr",    ovrCnt, 0);
    scoreOn = 1'b0;
    RxReady = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
